// File: rtl/uart_rx_frontend.sv
// -----------------------------------------------------------------------------
// uart_rx_frontend
//   UART receive front end: a 2-flop synchroniser on the RX pin, a
//   mid-bit-sampling receive FSM driven by a runtime baud divisor, and a small
//   first-word-fall-through FIFO that holds the received bytes and their
//   error flags.
//
// Build option:
//   UART_RX_PARITY_EN  defined   -> 11-bit frame (start, 8 data, even parity,
//                                   stop); rx_parity_err is live.
//                      undefined -> 10-bit 8N1 frame; rx_parity_err is tied 0.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   rx             asynchronous UART line (idle high)
//   divisor        bit period minus one, in clk cycles (minimum 1)
//   rx_valid       FIFO head is valid
//   rx_ready       consumer pops the head when rx_valid && rx_ready
//   rx_data        head data byte
//   rx_parity_err  head byte had a parity error
//   rx_frame_err   head byte had its stop bit sampled low
//   overflow       sticky: a byte was dropped because the FIFO was full
//   overflow_clr   clears overflow (a same-cycle overflow event wins)
//   busy           a frame is currently being received
// -----------------------------------------------------------------------------
module uart_rx_frontend #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  input  logic [DIV_W-1:0] divisor,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_parity_err,
  output logic             rx_frame_err,
  output logic             overflow,
  input  logic             overflow_clr,
  output logic             busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
`ifdef UART_RX_PARITY_EN
  localparam int ENTRY_W = 10;  // {frame_err, parity_err, data}
`else
  localparam int ENTRY_W = 9;   // {frame_err, data}
`endif
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Input synchroniser; resets to the idle (high) line level.
  // ---------------------------------------------------------------------------
  logic [1:0] sync_reg;
  logic       rx_s;

  always_ff @(posedge clk) begin
    if (reset) sync_reg <= 2'b11;
    else       sync_reg <= {sync_reg[0], rx};
  end

  assign rx_s = sync_reg[1];

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK   // stop bit was low: wait for the line to go high again
  } state_t;

  state_t             state_reg;
  logic [DIV_W-1:0]   cnt_reg;
  logic [2:0]         bit_reg;
  logic [7:0]         shift_reg;
  logic               cnt_zero;
  logic               push;
  logic [ENTRY_W-1:0] push_data;
`ifdef UART_RX_PARITY_EN
  logic               par_err_reg;
`endif

  assign cnt_zero = (cnt_reg == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_err_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!rx_s) begin
            // Half a bit period lands the start-bit check mid-bit.
            cnt_reg   <= divisor >> 1;
            state_reg <= ST_START;
          end
        end
        ST_START: begin
          if (cnt_zero) begin
            if (rx_s) begin
              state_reg <= ST_IDLE;  // glitch, not a real start bit
            end else begin
              cnt_reg   <= divisor;
              bit_reg   <= 3'd0;
              state_reg <= ST_DATA;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_zero) begin
            shift_reg[bit_reg] <= rx_s;  // LSB first
            cnt_reg            <= divisor;
            bit_reg            <= bit_reg + 3'd1;
            if (bit_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_reg <= ST_PARITY;
`else
              state_reg <= ST_STOP;
`endif
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt_zero) begin
            // Even parity: the parity bit equals the XOR of the data bits.
            par_err_reg <= rx_s ^ (^shift_reg);
            cnt_reg     <= divisor;
            state_reg   <= ST_STOP;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (cnt_zero) begin
            // The entry is pushed combinationally on this edge (see push).
            state_reg <= rx_s ? ST_IDLE : ST_BREAK;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_BREAK: begin
          if (rx_s) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Pushing on the stop-sample edge makes the entry visible one cycle later.
  assign push = (state_reg == ST_STOP) && cnt_zero;
`ifdef UART_RX_PARITY_EN
  assign push_data = {~rx_s, par_err_reg, shift_reg};
`else
  assign push_data = {~rx_s, shift_reg};
`endif

  assign busy = (state_reg != ST_IDLE);

  // ---------------------------------------------------------------------------
  // RX FIFO (first-word fall-through, registered head)
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [ENTRY_W-1:0] head_reg;
  logic               valid_reg;
  logic               overflow_reg;
  logic               full, pop, push_ok, ovf_event;

  assign full      = (count_reg == FULL_COUNT);
  assign pop       = valid_reg && rx_ready;
  // A pop in the same cycle frees a slot for a push into a full FIFO.
  assign push_ok   = push && (!full || pop);
  assign ovf_event = push && full && !pop;

  always_comb begin
    rd_ptr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    count_next  = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      head_reg     <= '0;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      valid_reg  <= (count_next != '0);
      // When the next head is the slot being written now, bypass the array.
      if (count_next != '0) begin
        if (push_ok && (rd_ptr_next == wr_ptr_reg)) head_reg <= push_data;
        else                                        head_reg <= mem[rd_ptr_next];
      end
      if (ovf_event)         overflow_reg <= 1'b1;
      else if (overflow_clr) overflow_reg <= 1'b0;
    end
  end

  assign rx_valid     = valid_reg;
  assign rx_data      = head_reg[7:0];
  assign rx_frame_err = head_reg[ENTRY_W-1];
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = head_reg[8];
`else
  assign rx_parity_err = 1'b0;
`endif
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frontend
//   Directed bench for uart_rx_frontend. Each sent frame pushes its expected
//   FIFO entry {frame_err, parity_err, data} into a queue; a monitor pops and
//   compares whenever the DUT hands over an entry (rx_valid && rx_ready).
//   Frame format follows UART_RX_PARITY_EN, same as the design.
// -----------------------------------------------------------------------------
module tb_uart_rx_frontend;

  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             rx;
  logic [DIV_W-1:0] divisor;
  logic             rx_valid;
  logic             rx_ready;
  logic [7:0]       rx_data;
  logic             rx_parity_err;
  logic             rx_frame_err;
  logic             overflow;
  logic             overflow_clr;
  logic             busy;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [9:0]  exp_q[$];
  logic [9:0]  got_e;
  logic [9:0]  exp_e;

  uart_rx_frontend #(.DIV_W(DIV_W), .FIFO_DEPTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx            (rx),
    .divisor       (divisor),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .overflow      (overflow),
    .overflow_clr  (overflow_clr),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // One bit period, starting just after a rising edge.
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (int'(divisor) + 1) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int nbits);
    rx = 1'b1;
    repeat (nbits * (int'(divisor) + 1) + 4) @(posedge clk);
    #1;
  endtask

  // Send one frame; optionally record the entry the DUT is expected to keep.
  task automatic send_frame(input logic [7:0] d, input logic par_bad,
                            input logic stop_bit, input logic expect_entry);
    logic pe;
`ifdef UART_RX_PARITY_EN
    pe = par_bad;
`else
    pe = 1'b0;
`endif
    if (expect_entry) exp_q.push_back({~stop_bit, pe, d});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_bad);
`endif
    drive_bit(stop_bit);
  endtask

  initial begin
    reset        = 1'b1;
    rx           = 1'b1;
    divisor      = 16'd1;
    rx_ready     = 1'b1;
    overflow_clr = 1'b0;

    // Scoreboard monitor: compares each handed-over entry against the queue.
    fork
      forever begin
        @(negedge clk);
        if (!reset && rx_valid && rx_ready) begin
          got_e = {rx_frame_err, rx_parity_err, rx_data};
          if (exp_q.size() == 0) begin
            chk("unexpected_entry", 32'(got_e), 32'h3FF);
          end else begin
            exp_e = exp_q.pop_front();
            chk("pop_entry", 32'(got_e), 32'(exp_e));
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    chk("reset_parity_err", 32'(rx_parity_err), 32'd0);
    chk("reset_frame_err", 32'(rx_frame_err), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    idle_bits(2);

    // Basic byte at 2 clk/bit.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    idle_bits(4);

    // divisor=3: parity error then a clean 0x00.
    divisor = 16'd3;
    idle_bits(2);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    idle_bits(4);
    send_frame(8'h00, 1'b0, 1'b1, 1'b1);
    idle_bits(4);

    // Framing error followed by a held-low line: exactly one entry.
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("break_busy_held", 32'(busy), 32'd1);
    idle_bits(4);
    chk("break_released", 32'(busy), 32'd0);
    send_frame(8'h12, 1'b0, 1'b1, 1'b1);
    idle_bits(4);

    // Overflow: 9 bytes into 8 slots with the consumer stalled.
    divisor  = 16'd1;
    rx_ready = 1'b0;
    idle_bits(2);
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b0, 1'b1, (i <= 8) ? 1'b1 : 1'b0);
      idle_bits(2);
    end
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_head_valid", 32'(rx_valid), 32'd1);
    chk("ovf_head_data", 32'(rx_data), 32'h01);
    overflow_clr = 1'b1;
    @(posedge clk);
    #1;
    overflow_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    rx_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("ovf_drained", 32'(rx_valid), 32'd0);

    // Glitch: one low cycle must not start a frame.
    divisor = 16'd7;
    idle_bits(1);
    rx = 1'b0;
    @(posedge clk);
    #1;
    rx = 1'b1;
    for (int k = 0; k < 8 && !busy; k++) begin
      @(posedge clk);
      #1;
    end
    chk("glitch_busy_seen", 32'(busy), 32'd1);
    for (int k = 0; k < 6 && busy; k++) begin
      @(posedge clk);
      #1;
    end
    chk("glitch_busy_clear", 32'(busy), 32'd0);
    idle_bits(2);
    chk("glitch_no_entry", 32'(rx_valid), 32'd0);

    // Reset in the middle of 0x77, then 0x81 must arrive intact.
    divisor = 16'd3;
    idle_bits(1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midreset_valid", 32'(rx_valid), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    idle_bits(2);
    chk("midreset_still_empty", 32'(rx_valid), 32'd0);
    send_frame(8'h81, 1'b0, 1'b1, 1'b1);
    idle_bits(4);

    // Fastest rate again with 0xF0.
    divisor = 16'd1;
    idle_bits(2);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b1);
    idle_bits(6);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
